// File: rtl/blink_period_meter.sv
`timescale 1ns/1ps
// blink_period_meter
// Measures the high and low half-periods of an asynchronous blink signal
// after synchronizing and debouncing it. Reports the full period, and raises
// stalled when no accepted edge has been seen for TIMEOUT_CYCLES cycles.
module blink_period_meter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES  = 100000000,
  parameter int CNT_W           = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             blink_in,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HALF,
    MEASURING,
    STALLED
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       interval_q, interval_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       half_period_q, half_period_d;
  logic [CNT_W-1:0]       prev_half_q, prev_half_d;
  logic [CNT_W:0]         period_q, period_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   stalled_q, stalled_d;
  logic [15:0]            edge_count_q, edge_count_d;

  logic                   sync_in;
  logic                   edge_accept;
  logic [CNT_W-1:0]       elapsed;
  logic                   timeout_hit;

  // Shift the raw pin into the synchronizer chain; only the last stage is used.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], blink_in};
    sync_in = sync_q[SYNC_STAGES-1];
  end

  // Debounce: a new level must persist for DEBOUNCE_CYCLES cycles before it is accepted.
  always_comb begin
    deb_cnt_d   = '0;
    level_d     = level_q;
    edge_accept = 1'b0;
    if (sync_in != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d     = ~level_q;
        edge_accept = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // interval_q counts the completed cycles since the last accepted edge; elapsed
  // also counts the current cycle, so it equals the distance between edge cycles.
  always_comb begin
    if (interval_q == TIMEOUT_VAL) begin
      elapsed = TIMEOUT_VAL;
    end else begin
      elapsed = interval_q + 1'b1;
    end
    timeout_hit = (elapsed == TIMEOUT_VAL);
    if (edge_accept) begin
      interval_d = '0;
    end else if (interval_q == TIMEOUT_VAL) begin
      interval_d = interval_q;
    end else begin
      interval_d = interval_q + 1'b1;
    end
  end

  // Accepted edges are counted in every state and wrap naturally at 16 bits.
  always_comb begin
    edge_count_d = edge_count_q;
    if (edge_accept) begin
      edge_count_d = edge_count_q + 16'd1;
    end
  end

  // Measurement sequencer: the edge after arming captures the first half-period,
  // every later edge reports a full period; an edge beats a coincident timeout.
  always_comb begin
    state_d       = state_q;
    half_period_d = half_period_q;
    prev_half_d   = prev_half_q;
    period_d      = period_q;
    meas_valid_d  = 1'b0;
    stalled_d     = stalled_q;
    case (state_q)
      IDLE: begin
        if (edge_accept) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (edge_accept) begin
          state_d       = HALF;
          half_period_d = elapsed;
          prev_half_d   = elapsed;
        end else if (timeout_hit) begin
          state_d   = STALLED;
          stalled_d = 1'b1;
        end
      end
      HALF, MEASURING: begin
        if (edge_accept) begin
          state_d       = MEASURING;
          half_period_d = elapsed;
          prev_half_d   = elapsed;
          period_d      = {1'b0, elapsed} + {1'b0, prev_half_q};
          meas_valid_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = STALLED;
          stalled_d = 1'b1;
        end
      end
      STALLED: begin
        if (edge_accept) begin
          state_d   = ARMED;
          stalled_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to IDLE with zeroed outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q        <= '0;
      deb_cnt_q     <= '0;
      level_q       <= 1'b0;
      interval_q    <= '0;
      state_q       <= IDLE;
      half_period_q <= '0;
      prev_half_q   <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      stalled_q     <= 1'b0;
      edge_count_q  <= '0;
    end else begin
      sync_q        <= sync_d;
      deb_cnt_q     <= deb_cnt_d;
      level_q       <= level_d;
      interval_q    <= interval_d;
      state_q       <= state_d;
      half_period_q <= half_period_d;
      prev_half_q   <= prev_half_d;
      period_q      <= period_d;
      meas_valid_q  <= meas_valid_d;
      stalled_q     <= stalled_d;
      edge_count_q  <= edge_count_d;
    end
  end

  assign level       = level_q;
  assign half_period = half_period_q;
  assign period      = period_q;
  assign meas_valid  = meas_valid_q;
  assign stalled     = stalled_q;
  assign edge_count  = edge_count_q;

endmodule

// File: doc/blink_period_meter.md
# blink_period_meter

Receive-side companion to the LED blinker. It samples an asynchronous blink signal, such as a looped-back LED line or a GPIO pin, through a synchronizer and debouncer. It measures the high and low half-periods in CLOCK_50 cycles, reports the full period, and flags when the signal stops toggling. It sits between the board pin and the display or checking logic.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchronizer (at least 2).
- DEBOUNCE_CYCLES, 1000: consecutive cycles a new level must persist before it is accepted.
- TIMEOUT_CYCLES, 100000000: cycles with no accepted edge before stall is declared.
- CNT_W, 32: interval counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLOCK_50  in  1: the single clock.
- reset  in  1: synchronous, active-high.
- blink_in  in  1: asynchronous blink input.
- level  out  1: debounced level.
- half_period  out  CNT_W: cycles between the last two accepted edges.
- period  out  CNT_W+1: sum of the last two half-periods.
- meas_valid  out  1: one-cycle pulse; half_period and period are updated.
- stalled  out  1: no accepted edge for TIMEOUT_CYCLES.
- edge_count  out  16: count of accepted edges.

## Operation
- **Synchronizer.** blink_in passes through a SYNC_STAGES flip-flop chain; only the last stage is used.
- **Debouncer.**
  - A counter increments while the synchronized input differs from `level`.
  - It clears to 0 whenever the input equals `level`.
  - When it reaches DEBOUNCE_CYCLES, `level` toggles and the counter clears; that cycle is an accepted edge.
  - Rising and falling edges are treated identically.
- **Interval counter.**
  - Clears to 0 on every accepted edge, then increments once per cycle.
  - Saturates at TIMEOUT_CYCLES.
  - The value captured at an edge equals the number of cycles between the two accepted-edge cycles.
- **State machine.**
  - IDLE (reset): first edge -> ARMED.
  - ARMED: edge -> HALF. half_period loads the interval and prev_half stores it. No meas_valid.
  - HALF: edge -> MEASURING. half_period loads the interval, period = interval + prev_half, meas_valid pulses.
  - MEASURING: every edge does the same as HALF and stays in MEASURING.
  - ARMED, HALF or MEASURING: interval reaches TIMEOUT_CYCLES with no edge -> STALLED, and stalled is set.
  - IDLE never times out.
  - STALLED: edge -> ARMED and stalled clears. No measurement is reported; the sequence restarts, and half_period and period hold their last values.
- **Simultaneous edge and timeout.** An edge in the cycle the interval reaches TIMEOUT_CYCLES wins: it is measured with value TIMEOUT_CYCLES and the stall is not entered.
- **edge_count.** Increments on every accepted edge in any state and wraps 0xFFFF -> 0x0000. It is not cleared by a stall.
- **Arithmetic.** `period` is computed at CNT_W+1 bits and cannot overflow.

## Timing
- **Reset values.** All outputs are 0; state is IDLE; synchronizer, debounce and interval counters are 0.
- **Reset mid-operation.**
  - Any state returns to IDLE in the next cycle and all measurements are lost.
  - If blink_in is high at reset release, it is accepted as a rising edge after debounce and counted as the first edge.
- **Input-to-level latency.** A clean level change on blink_in appears on `level` SYNC_STAGES + DEBOUNCE_CYCLES cycles later.
- **Output registration.**
  - half_period, period and meas_valid are registered and update one cycle after the accepted-edge cycle.
  - stalled and edge_count also update one cycle after their causing event.
- **meas_valid.** Exactly one cycle wide. Never asserted in IDLE, ARMED, or on the ARMED->HALF edge.
- **Glitch rejection.** A pulse shorter than DEBOUNCE_CYCLES at the synchronizer output produces no edge and leaves every output unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200, SYNC_STAGES=2.
1. **Symmetric wave.** Square wave, 50 cycles high / 50 low, from reset -> first meas_valid on the 3rd accepted edge with half_period=50, period=100, edge_count=3. Every later edge pulses with the same values.
2. **Asymmetric wave.** 30 high / 70 low -> half_period alternates 30 and 70; period=100 on every pulse.
3. **Glitch rejection.** 3-cycle glitches on a steady low input -> level stays 0, edge_count stays 0, no meas_valid.
4. **Stall and restart.**
   - Stop toggling in MEASURING -> stalled=1 exactly 201 cycles after the last edge cycle; half_period and period hold.
   - Next edge -> stalled=0 and edge_count+1, but no meas_valid until two further edges.
5. **Reset mid-measurement.** Reset asserted in MEASURING while blink_in is held high -> all outputs 0 the following cycle. After release, level=1 and edge_count=1 at cycle 7; no meas_valid.
6. **Counter wrap and edge/timeout race.**
   - Preload edge_count to 0xFFFF via 65535 edges, or a forced start -> the next edge gives 0x0000.
   - An edge landing exactly on interval=200 -> half_period=200 and stalled stays 0.
